// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : coin codes, coin unit values and acceptor states shared by the
//            coin acceptor front-end and the downstream vending FSM.
// Revision : 1.0
// ============================================================================
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam logic [2:0] UNIT_5  = 3'd1;
  localparam logic [2:0] UNIT_10 = 3'd2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    GAP     = 2'd2
  } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/coin_fifo.sv
`default_nettype none
// ============================================================================
// coin_fifo : synchronous FIFO holding classified coin codes for one
//             transaction; last_o flags a single remaining entry.
// Revision  : 1.0
// ============================================================================
module coin_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] c_ptr_max = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth   = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == c_ptr_max) ? '0 : ptr + AW'(1);
  endfunction

  assign full_o  = (count_q == c_depth);
  assign empty_o = (count_q == '0);
  assign last_o  = (count_q == CW'(1));
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// coin_acceptor : synchronises the coin sense line, classifies pulse widths
//                 into 5/10 rs coins and releases each transaction as one
//                 contiguous burst of coin codes followed by idle.
// Revision      : 1.0
// ============================================================================
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned SHORT_MIN   = 4,
  parameter int unsigned SHORT_MAX   = 12,
  parameter int unsigned LONG_MIN    = 20,
  parameter int unsigned LONG_MAX    = 40,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PRICE_UNITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense_i,
  input  logic       cancel_i,
  output logic [1:0] coin_code_o,
  output logic       busy_o,
  output logic       reject_o
);

  localparam int unsigned CW = $clog2(LONG_MAX + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_sat       = CW'(LONG_MAX + 1);
  localparam logic [CW-1:0] c_short_min = CW'(SHORT_MIN);
  localparam logic [CW-1:0] c_short_max = CW'(SHORT_MAX);
  localparam logic [CW-1:0] c_long_min  = CW'(LONG_MIN);
  localparam logic [CW-1:0] c_long_max  = CW'(LONG_MAX);
  localparam logic [TW-1:0] c_timeout   = TW'(TIMEOUT);
  localparam logic [2:0]    c_price     = 3'(PRICE_UNITS);

  acc_state_e    state_q, state_d;
  logic          sync1_q, sense_q, prev_q;
  logic [CW-1:0] width_q, width_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    sum_q, sum_d;
  logic          reject_q, reject_d;

  logic          fall, is_short, is_long, push, pop;
  logic [1:0]    coin_in, fifo_head;
  logic [2:0]    unit;
  logic [3:0]    sum_add;
  logic          fifo_full, fifo_empty, fifo_last;

  coin_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (coin_in),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sense_q  <= 1'b0;
      prev_q   <= 1'b0;
      width_q  <= '0;
      timer_q  <= '0;
      sum_q    <= '0;
      reject_q <= 1'b0;
      state_q  <= COLLECT;
    end else begin
      sync1_q  <= coin_sense_i;
      sense_q  <= sync1_q;
      prev_q   <= sense_q;
      width_q  <= width_d;
      timer_q  <= timer_d;
      sum_q    <= sum_d;
      reject_q <= reject_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    fall     = prev_q & ~sense_q;
    is_short = (width_q >= c_short_min) && (width_q <= c_short_max);
    is_long  = (width_q >= c_long_min) && (width_q <= c_long_max);
    coin_in  = is_long ? COIN_10 : COIN_5;
    unit     = is_long ? UNIT_10 : UNIT_5;
    // Coins are only buffered while collecting; anything else is dropped.
    push     = fall & (is_short | is_long) & (state_q == COLLECT) & ~fifo_full;
    reject_d = fall & ~push;

    width_d = width_q;
    if (fall)                          width_d = '0;
    else if (sense_q && width_q != c_sat) width_d = width_q + CW'(1);

    sum_add = {1'b0, sum_q} + {1'b0, unit};
    sum_d   = sum_q;
    if (push) sum_d = sum_add[3] ? 3'd7 : sum_add[2:0];

    state_d     = state_q;
    timer_d     = '0;
    pop         = 1'b0;
    coin_code_o = COIN_NONE;
    busy_o      = (state_q != COLLECT);

    case (state_q)
      COLLECT: begin
        if (push || fifo_empty)                  timer_d = '0;
        else if (!sense_q && timer_q != c_timeout) timer_d = timer_q + TW'(1);
        else                                     timer_d = timer_q;
        // Post-push view so a coin landing on the decision cycle joins the burst.
        if ((sum_d >= c_price) ||
            ((!fifo_empty || push) && (timer_q == c_timeout || cancel_i))) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        coin_code_o = fifo_head;
        pop         = 1'b1;
        if (fifo_last) state_d = GAP;
      end
      GAP: begin
        sum_d   = '0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign reject_o = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// tb_coin_acceptor : directed and randomised coin sequences checked against a
//                    value/queue model of the acceptor's transaction rules.
// Revision         : 1.0
// ============================================================================
module tb_coin_acceptor;
  import vend_pkg::*;

  localparam int TIMEOUT = 1000;
  localparam int PRICE   = 3;

  logic       clk = 1'b0;
  logic       rst, coin_sense, cancel;
  logic [1:0] coin_code;
  logic       busy, reject;

  int total = 0;
  int bad   = 0;
  int rej_seen = 0;
  int nz_seen  = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  coin_acceptor #(
    .SHORT_MIN(4), .SHORT_MAX(12), .LONG_MIN(20), .LONG_MAX(40),
    .TIMEOUT(TIMEOUT), .DEPTH(4), .PRICE_UNITS(PRICE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_sense_i (coin_sense),
    .cancel_i     (cancel),
    .coin_code_o  (coin_code),
    .busy_o       (busy),
    .reject_o     (reject)
  );

  always @(negedge clk) begin
    if (!rst && reject) rej_seen++;
    if (coin_code !== 2'b00) nz_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Coin value in 5 rs units from pulse width; 0 means not a coin.
  function automatic int coin_value(input int w);
    if (w >= 4 && w <= 12)  return 1;
    if (w >= 20 && w <= 40) return 2;
    return 0;
  endfunction

  function automatic logic [1:0] code_of(input int v);
    return (v == 2) ? COIN_10 : COIN_5;
  endfunction

  function automatic int rand_bad_width();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(1, 3);
      1:       return $urandom_range(13, 19);
      default: return $urandom_range(41, 60);
    endcase
  endfunction

  task automatic send_pulse(input int w);
    coin_sense = 1'b1;
    repeat (w) tick();
    coin_sense = 1'b0;
  endtask

  // Waits (bounded) for a burst, then checks it against exp_q, the GAP and idle.
  task automatic check_burst(input string tag, input int max_wait, input int exp_start);
    int waited = 0;
    while (coin_code === 2'b00 && waited < max_wait) begin
      tick();
      waited++;
    end
    chk($sformatf("%s arrived", tag), 32'(coin_code !== 2'b00), 1);
    if (exp_start >= 0) chk($sformatf("%s start", tag), waited, exp_start);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s code%0d", tag, i), coin_code, exp_q[i]);
      chk($sformatf("%s busy%0d", tag, i), busy, 1);
      tick();
    end
    chk($sformatf("%s end code", tag), coin_code, 0);
    chk($sformatf("%s gap busy", tag), busy, 1);
    tick();
    chk($sformatf("%s idle busy", tag), busy, 0);
    exp_q.delete();
  endtask

  task automatic run_txn(input int k);
    int sum = 0;
    int exp_rej = 0;
    int r0 = rej_seen;
    int w, v;
    while (sum < PRICE) begin
      if ($urandom_range(0, 3) == 0) begin
        send_pulse(rand_bad_width());
        exp_rej++;
        repeat ($urandom_range(3, 12)) tick();
      end
      w = ($urandom_range(0, 1) == 0) ? $urandom_range(4, 12) : $urandom_range(20, 40);
      v = coin_value(w);
      exp_q.push_back(code_of(v));
      sum += v;
      send_pulse(w);
      if (sum < PRICE) repeat ($urandom_range(3, 15)) tick();
    end
    check_burst($sformatf("txn%0d", k), 10, 3);
    chk($sformatf("txn%0d rejects", k), rej_seen - r0, exp_rej);
  endtask

  initial begin
    int r0, n0;
    rst = 1'b1;
    coin_sense = 1'b0;
    cancel = 1'b0;
    repeat (3) tick();
    chk("reset code", coin_code, 0);
    chk("reset busy", busy, 0);
    chk("reset reject", reject, 0);
    rst = 1'b0;
    tick();

    // 5 + 10 reaches the price on the second coin.
    r0 = rej_seen;
    exp_q.push_back(COIN_5);
    exp_q.push_back(COIN_10);
    send_pulse(8);
    repeat (5) tick();
    send_pulse(30);
    check_burst("5+10", 10, 3);
    chk("5+10 rejects", rej_seen - r0, 0);

    // Three 5 rs coins.
    repeat (3) exp_q.push_back(COIN_5);
    send_pulse(8); repeat (6) tick();
    send_pulse(8); repeat (6) tick();
    send_pulse(8);
    check_burst("3x5", 10, 3);

    // Single 10 rs coin released by the idle timeout.
    exp_q.push_back(COIN_10);
    send_pulse(30);
    check_burst("timeout", TIMEOUT + 20, TIMEOUT + 4);

    // Bad widths: rejected, nothing buffered.
    r0 = rej_seen;
    n0 = nz_seen;
    send_pulse(2);
    tick(); tick();
    chk("reject early", reject, 0);
    tick();
    chk("reject pulse", reject, 1);
    tick();
    chk("reject one cycle", reject, 0);
    repeat (5) tick();
    send_pulse(15); repeat (6) tick();
    send_pulse(60); repeat (6) tick();
    chk("bad rejects", rej_seen - r0, 3);
    cancel = 1'b1;
    repeat (4) tick();
    cancel = 1'b0;
    repeat (3) tick();
    chk("bad no code", nz_seen - n0, 0);
    chk("empty cancel busy", busy, 0);

    // Cancel with one buffered 5 rs coin at timer=10.
    exp_q.push_back(COIN_5);
    send_pulse(8);
    repeat (13) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_burst("cancel", 2, 0);

    // Coin whose falling edge lands in EMIT is dropped.
    r0 = rej_seen;
    send_pulse(6); repeat (4) tick();
    send_pulse(10); repeat (4) tick();
    send_pulse(8);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    exp_q.push_back(COIN_5);
    exp_q.push_back(COIN_5);
    check_burst("inburst", 2, 0);
    repeat (3) tick();
    chk("inburst rejects", rej_seen - r0, 1);

    // Reset in the middle of a burst.
    send_pulse(8); repeat (4) tick();
    send_pulse(8); repeat (4) tick();
    send_pulse(30);
    repeat (3) tick();
    chk("pre-reset head", coin_code, COIN_5);
    rst = 1'b1;
    tick();
    chk("mid-reset code", coin_code, 0);
    chk("mid-reset busy", busy, 0);
    rst = 1'b0;
    tick();
    n0 = nz_seen;
    cancel = 1'b1;
    repeat (3) tick();
    cancel = 1'b0;
    repeat (4) tick();
    chk("post-reset fifo empty", nz_seen - n0, 0);
    chk("post-reset busy", busy, 0);

    for (int k = 0; k < 8; k++) run_txn(k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
